// File: rtl/fifo_wr_ctrl.sv
// Write-side controller for the async FIFO: round-robin arbitration of NREQ
// producers onto the single RAM write port, plus Gray write pointer and full/free status.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 8,
  parameter int NREQ         = 4,
  parameter int AFULL_THRESH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            gnt,
  output logic                       mem_we,
  output logic [ADDR_WIDTH-1:0]      mem_waddr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  output logic [ADDR_WIDTH:0]        wptr_gray,
  input  logic [ADDR_WIDTH:0]        rptr_gray_sync,
  output logic                       full,
  output logic                       almost_full,
  output logic [ADDR_WIDTH:0]        free_cnt
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] DEPTH = PW'(2 ** ADDR_WIDTH);

  logic [PW-1:0]         r_wbin;
  logic [PW-1:0]         r_wgray;
  logic                  r_full;
  logic                  r_afull;
  logic [PW-1:0]         r_free;
  logic [IW-1:0]         r_rr_last;

  logic [NREQ-1:0]       w_gnt;
  logic [IW-1:0]         w_gnt_idx;
  logic [IW-1:0]         w_i;
  logic                  w_found;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [PW-1:0]         w_wbin_next;
  logic [PW-1:0]         w_wgray_next;
  logic [PW-1:0]         w_rbin;
  logic [PW-1:0]         w_free_next;
  logic                  w_full_next;

  // Scan starts one past the last winner; gating on rst_n keeps gnt low while reset is held.
  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_i       = '0;
    w_found   = 1'b0;
    if (rst_n && !r_full) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        w_i = IW'((32'(r_rr_last) + 32'd1 + k) % NREQ);
        if (!w_found && req[w_i]) begin
          w_found     = 1'b1;
          w_gnt[w_i]  = 1'b1;
          w_gnt_idx   = w_i;
        end
      end
    end
  end

  always_comb begin
    w_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) w_wdata = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    w_rbin = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      w_rbin[i] = ^(rptr_gray_sync >> i);
    end
  end

  always_comb begin
    w_wbin_next  = r_wbin + {{(PW-1){1'b0}}, w_found};
    w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);
    w_full_next  = (w_wgray_next ==
                    {~rptr_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1], rptr_gray_sync[ADDR_WIDTH-2:0]});
    w_free_next  = DEPTH - (w_wbin_next - w_rbin);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbin    <= '0;
      r_wgray   <= '0;
      r_full    <= 1'b0;
      r_afull   <= 1'b0;
      r_free    <= DEPTH;
      r_rr_last <= IW'(NREQ - 1);
    end else begin
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
      r_full  <= w_full_next;
      r_afull <= (w_free_next <= PW'(AFULL_THRESH));
      r_free  <= w_free_next;
      if (w_found) r_rr_last <= w_gnt_idx;
    end
  end

  assign gnt         = w_gnt;
  assign mem_we      = w_found;
  assign mem_waddr   = r_wbin[ADDR_WIDTH-1:0];
  assign mem_wdata   = w_wdata;
  assign wptr_gray   = r_wgray;
  assign full        = r_full;
  assign almost_full = r_afull;
  assign free_cnt    = r_free;

endmodule
